// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq
// Memory sequencer sitting on the shared master port behind the 4-way arbiter.
// Accepts one req/rdy transaction at a time and drives a synchronous
// single-port RAM whose read latency is fixed at RD_LAT cycles. Out-of-range
// byte addresses are answered immediately with err_m and never touch the RAM.
// Good reads, good writes and errors are counted.
//
// Ports
//   clk, reset           clock (posedge) and synchronous active-high reset
//   addr_m, dout_m       byte address and write data from the arbiter
//   req_m, wr_m          request (held until rdy_m) and write/read select
//   din_m                read data back to the arbiter (0 on error)
//   rdy_m, err_m         one-cycle completion pulse and its error qualifier
//   ram_addr/en/we/wdata RAM command port; ram_rdata returns RD_LAT later
//   rd_cnt, wr_cnt       completed good reads / writes, wrapping
//   err_cnt              out-of-range transactions, saturating
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_seq #(
    parameter int RAM_AW = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       addr_m,
    input  logic [63:0]       dout_m,
    output logic [63:0]       din_m,
    input  logic              req_m,
    input  logic              wr_m,
    output logic              rdy_m,
    output logic              err_m,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [15:0]       err_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RD_WAIT = 3'd2,
        RESP    = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              wr_r;
    logic              wr_s;
    logic [2:0]        lat_cnt_r;
    logic [2:0]        lat_cnt_s;

    logic [63:0]       din_s;
    logic              rdy_s;
    logic              err_s;
    logic [RAM_AW-1:0] ram_addr_s;
    logic              ram_en_s;
    logic              ram_we_s;
    logic [63:0]       ram_wdata_s;
    logic [31:0]       rd_cnt_s;
    logic [31:0]       wr_cnt_s;
    logic [15:0]       err_cnt_s;

    // Any address bit above the RAM's byte space makes the access illegal;
    // the byte-lane bits [2:0] never matter.
    function automatic logic addr_in_range(input logic [63:0] a);
        return ((a >> (RAM_AW + 3)) == 64'd0);
    endfunction

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_s     = state_r;
        wr_s        = wr_r;
        lat_cnt_s   = lat_cnt_r;
        din_s       = din_m;
        rdy_s       = 1'b0;
        err_s       = 1'b0;
        ram_addr_s  = ram_addr;
        ram_en_s    = 1'b0;
        ram_we_s    = ram_we;
        ram_wdata_s = ram_wdata;
        rd_cnt_s    = rd_cnt;
        wr_cnt_s    = wr_cnt;
        err_cnt_s   = err_cnt;

        case (state_r)
            IDLE: begin
                if (req_m) begin
                    wr_s = wr_m;
                    if (!addr_in_range(addr_m)) begin
                        // Answer at once, nothing reaches the RAM.
                        state_s = RESP;
                        rdy_s   = 1'b1;
                        err_s   = 1'b1;
                        din_s   = 64'd0;
                    end else begin
                        // RAM command is launched as the request is taken so
                        // that ram_en is high for exactly the ACCESS cycle.
                        state_s     = ACCESS;
                        ram_en_s    = 1'b1;
                        ram_addr_s  = addr_m[RAM_AW+2:3];
                        ram_we_s    = wr_m;
                        ram_wdata_s = dout_m;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            ACCESS: begin
                if (wr_r) begin
                    state_s = RESP;
                    rdy_s   = 1'b1;
                end else begin
                    // RD_LAT cycles of wait; the last one captures ram_rdata.
                    state_s   = RD_WAIT;
                    lat_cnt_s = 3'(RD_LAT - 1);
                end
            end

            RD_WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    state_s = RESP;
                    din_s   = ram_rdata;
                    rdy_s   = 1'b1;
                end else begin
                    lat_cnt_s = lat_cnt_r - 3'd1;
                end
            end

            RESP: begin
                state_s = GAP;
                // err_m is still high here for a rejected transaction.
                if (err_m) begin
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt_s = err_cnt + 16'd1;
                    end else begin
                        err_cnt_s = err_cnt;
                    end
                end else if (wr_r) begin
                    wr_cnt_s = wr_cnt + 32'd1;
                end else begin
                    rd_cnt_s = rd_cnt + 32'd1;
                end
            end

            GAP: begin
                // Requests are deliberately not looked at in this cycle.
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            wr_r      <= 1'b0;
            lat_cnt_r <= 3'd0;
            din_m     <= 64'd0;
            rdy_m     <= 1'b0;
            err_m     <= 1'b0;
            ram_addr  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 64'd0;
            rd_cnt    <= 32'd0;
            wr_cnt    <= 32'd0;
            err_cnt   <= 16'd0;
        end else begin
            state_r   <= state_s;
            wr_r      <= wr_s;
            lat_cnt_r <= lat_cnt_s;
            din_m     <= din_s;
            rdy_m     <= rdy_s;
            err_m     <= err_s;
            ram_addr  <= ram_addr_s;
            ram_en    <= ram_en_s;
            ram_we    <= ram_we_s;
            ram_wdata <= ram_wdata_s;
            rd_cnt    <= rd_cnt_s;
            wr_cnt    <= wr_cnt_s;
            err_cnt   <= err_cnt_s;
        end
    end

endmodule
